seg7_scan_driver: RTL

//  Downstream of the display-code stage. Time-multiplexes the six 4-bit digit codes (req_digit0..5) onto one

---
 rtl/seg7_scan_driver.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/seg7_scan_driver.sv
// Six-digit multiplexed 7-segment driver: per-frame digit snapshot, anode ghost-guard and one decimal point.
// Optional blinking is compiled in when the macro DISP_BLINK_EN is defined.
module seg7_scan_driver #(
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 16,
    parameter int DP_DIGIT       = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1,
    parameter int BLINK_FRAMES   = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req_digit0,
    input  logic [3:0] req_digit1,
    input  logic [3:0] req_digit2,
    input  logic [3:0] req_digit3,
    input  logic [3:0] req_digit4,
    input  logic [3:0] req_digit5,
    input  logic       dp_en,
    input  logic       blink,
    output logic [6:0] seg,
    output logic       dp,
    output logic [5:0] an,
    output logic       frame_tick
);

    localparam int              CW        = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0]   GUARD_CNT = CW'(GUARD);
    localparam logic [2:0]      DP_SLOT   = 3'(DP_DIGIT);

    generate
        if (REFRESH_DIV < GUARD + 2) begin : g_param_check
            $error("seg7_scan_driver: REFRESH_DIV must be at least GUARD+2");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic [2:0]    r_slot;
    logic [3:0]    r_shadow [6];
    logic          r_shadow_dp;
    logic          r_shadow_blink;
    logic          r_load_pend;
    logic          r_frame_tick;
    logic [5:0]    r_an;
    logic [6:0]    r_seg;
    logic          r_dp;

    logic [3:0]    w_req [6];
    logic          w_slot_end;
    logic          w_snap;
    logic          w_guard_done;
    logic          w_phase_on;
    logic          w_visible;
    logic [5:0]    w_an_int;
    logic [6:0]    w_seg_int;
    logic          w_dp_int;

    assign w_req[0] = req_digit0;
    assign w_req[1] = req_digit1;
    assign w_req[2] = req_digit2;
    assign w_req[3] = req_digit3;
    assign w_req[4] = req_digit4;
    assign w_req[5] = req_digit5;

    function automatic logic [6:0] decode(input logic [3:0] code);
        logic [6:0] g;
        case (code)
            4'h0: g = 7'h3F;
            4'h1: g = 7'h06;
            4'h2: g = 7'h5B;
            4'h3: g = 7'h4F;
            4'h4: g = 7'h66;
            4'h5: g = 7'h6D;
            4'h6: g = 7'h7D;
            4'h7: g = 7'h07;
            4'h8: g = 7'h7F;
            4'h9: g = 7'h6F;
            4'hA: g = 7'h77;
            4'hB: g = 7'h7C;
            4'hC: g = 7'h39;
            4'hD: g = 7'h5E;
            4'hE: g = 7'h79;
            default: g = 7'h00;  // code F is the blank glyph
        endcase
        return g;
    endfunction

    assign w_slot_end   = (r_cnt == CNT_LAST);
    // load_pend forces a capture on the first cycle out of reset so the display never waits a full frame.
    assign w_snap       = (w_slot_end && (r_slot == 3'd5)) || r_load_pend;
    assign w_guard_done = (r_cnt >= GUARD_CNT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_slot <= 3'd0;
        end else if (w_slot_end) begin
            r_cnt  <= '0;
            r_slot <= (r_slot == 3'd5) ? 3'd0 : r_slot + 3'd1;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 6; i++) begin
                r_shadow[i] <= 4'hF;
            end
            r_shadow_dp    <= 1'b0;
            r_shadow_blink <= 1'b0;
            r_load_pend    <= 1'b1;
            r_frame_tick   <= 1'b0;
        end else begin
            r_frame_tick <= w_snap;
            if (w_snap) begin
                for (int i = 0; i < 6; i++) begin
                    r_shadow[i] <= w_req[i];
                end
                r_shadow_dp    <= dp_en;
                r_shadow_blink <= blink;
                r_load_pend    <= 1'b0;
            end
        end
    end

`ifdef DISP_BLINK_EN
    // Counts snapshots within the current blink half-period; the snapshot that toggles the
    // phase is the first frame of the new half-period, hence the reload to 1.
    localparam int FW = $clog2(BLINK_FRAMES + 1);

    logic [FW-1:0] r_frame_cnt;
    logic          r_phase_on;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (w_snap) begin
            if (r_frame_cnt == FW'(BLINK_FRAMES)) begin
                r_frame_cnt <= FW'(1);
                r_phase_on  <= ~r_phase_on;
            end else begin
                r_frame_cnt <= r_frame_cnt + 1'b1;
            end
        end
    end

    assign w_phase_on = r_phase_on;
`else
    assign w_phase_on = 1'b1;
`endif

    assign w_visible = w_guard_done && (w_phase_on || !r_shadow_blink);
    assign w_an_int  = w_visible ? (6'b000001 << r_slot) : 6'b000000;
    assign w_seg_int = decode(r_shadow[r_slot]);
    assign w_dp_int  = r_shadow_dp && (r_slot == DP_SLOT) && w_visible;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an  <= 6'b000000;
            r_seg <= 7'b0000000;
            r_dp  <= 1'b0;
        end else begin
            r_an  <= w_an_int;
            r_seg <= w_seg_int;
            r_dp  <= w_dp_int;
        end
    end

    // Pin polarity is applied after the registers so the reset state is always "everything dark".
    assign an         = (AN_ACTIVE_LOW != 0)  ? ~r_an  : r_an;
    assign seg        = (SEG_ACTIVE_LOW != 0) ? ~r_seg : r_seg;
    assign dp         = (SEG_ACTIVE_LOW != 0) ? ~r_dp  : r_dp;
    assign frame_tick = r_frame_tick;

endmodule
